// File: rtl/ps2_move_scheduler_pkg.sv
// Shared constants for the PS/2 move scheduler: scan codes, direction encoding
// and held-bit positions (held bit index equals the direction code).
package ps2_move_scheduler_pkg;

   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_e;

   localparam int HELD_UP    = 0;
   localparam int HELD_DOWN  = 1;
   localparam int HELD_LEFT  = 2;
   localparam int HELD_RIGHT = 3;

   // Fallback direction after releasing the active key: up > down > left > right.
   function automatic dir_e prio_dir(input logic [3:0] held);
      if (held[HELD_UP])
         return DIR_UP;
      else if (held[HELD_DOWN])
         return DIR_DOWN;
      else if (held[HELD_LEFT])
         return DIR_LEFT;
      return DIR_RIGHT;
   endfunction

endpackage

// File: rtl/ps2_move_scheduler_parser.sv
// Scan-code parser: break/ext prefix flags, key map for both players and the
// held-key / last-direction bookkeeping.
module ps2_code_parser
   import ps2_move_scheduler_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       code_valid_i,
   input  logic [7:0] code_i,
   output logic [3:0] held_p0_o,
   output logic [3:0] held_p1_o,
   output dir_e       last_dir_p0_o,
   output dir_e       last_dir_p1_o
);

   logic            brk_q, brk_d;
   logic            ext_q, ext_d;
   logic [1:0][3:0] held_q, held_d;
   logic [1:0][1:0] last_q, last_d;

   logic       hit;
   logic       hit_p;
   dir_e       hit_dir;
   logic [3:0] remaining;

   always_comb begin
      hit     = 1'b0;
      hit_p   = 1'b0;
      hit_dir = DIR_UP;
      if (!ext_q) begin
         case (code_i)
            SC_W:    begin hit = 1'b1; hit_dir = DIR_UP;    end
            SC_S:    begin hit = 1'b1; hit_dir = DIR_DOWN;  end
            SC_A:    begin hit = 1'b1; hit_dir = DIR_LEFT;  end
            SC_D:    begin hit = 1'b1; hit_dir = DIR_RIGHT; end
            default: ;
         endcase
      end else begin
         hit_p = 1'b1;
         case (code_i)
            SC_UP:    begin hit = 1'b1; hit_dir = DIR_UP;    end
            SC_DOWN:  begin hit = 1'b1; hit_dir = DIR_DOWN;  end
            SC_LEFT:  begin hit = 1'b1; hit_dir = DIR_LEFT;  end
            SC_RIGHT: begin hit = 1'b1; hit_dir = DIR_RIGHT; end
            default:  ;
         endcase
      end
   end

   always_comb begin
      brk_d     = brk_q;
      ext_d     = ext_q;
      held_d    = held_q;
      last_d    = last_q;
      remaining = held_q[hit_p] & ~(4'b0001 << hit_dir);
      if (code_valid_i) begin
         if (code_i == SC_BREAK) begin
            brk_d = 1'b1;
         end else if (code_i == SC_EXT) begin
            ext_d = 1'b1;
         end else begin
            brk_d = 1'b0;
            ext_d = 1'b0;
            if (hit && !brk_q) begin
               held_d[hit_p][hit_dir] = 1'b1;
               last_d[hit_p]          = hit_dir;
            end else if (hit && held_q[hit_p][hit_dir]) begin
               held_d[hit_p][hit_dir] = 1'b0;
               // Only the active direction falls back; an idle player keeps its stale last_dir.
               if (last_q[hit_p] == hit_dir && remaining != 4'b0000)
                  last_d[hit_p] = prio_dir(remaining);
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         brk_q  <= 1'b0;
         ext_q  <= 1'b0;
         held_q <= '0;
         last_q <= '0;
      end else begin
         brk_q  <= brk_d;
         ext_q  <= ext_d;
         held_q <= held_d;
         last_q <= last_d;
      end
   end

   assign held_p0_o     = held_q[0];
   assign held_p1_o     = held_q[1];
   assign last_dir_p0_o = dir_e'(last_q[0]);
   assign last_dir_p1_o = dir_e'(last_q[1]);

endmodule

// File: rtl/ps2_move_scheduler.sv
// Two-player move scheduler: per-player repeat counters and pending moves,
// arbitrated round-robin into a single registered valid/ready move port.
module ps2_move_scheduler
   import ps2_move_scheduler_pkg::*;
#(
   parameter int REPEAT_TICKS = 1
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       code_valid,
   input  logic [7:0] code,
   input  logic       game_tick,
   input  logic       move_ready,
   output logic       move_valid,
   output logic       move_player,
   output logic [1:0] move_dir,
   output logic [3:0] held_p0,
   output logic [3:0] held_p1,
   output logic       overrun
);

   localparam logic [7:0] RELOAD = 8'(REPEAT_TICKS - 1);

   dir_e            last_dir_p0, last_dir_p1;
   logic [1:0][3:0] held;
   logic [1:0][1:0] last_dir;
   logic [1:0]      sched;

   ps2_code_parser u_parser (
      .clk_i         (CLOCK_50),
      .rst_i         (reset),
      .code_valid_i  (code_valid),
      .code_i        (code),
      .held_p0_o     (held_p0),
      .held_p1_o     (held_p1),
      .last_dir_p0_o (last_dir_p0),
      .last_dir_p1_o (last_dir_p1)
   );

   assign held     = {held_p1, held_p0};
   assign last_dir = {last_dir_p1, last_dir_p0};

   for (genvar gi = 0; gi < 2; gi++) begin : g_repeat
      logic [7:0] cnt_q, cnt_d;
      logic       fire;

      always_comb begin
         cnt_d = cnt_q;
         fire  = 1'b0;
         if (game_tick) begin
            if (held[gi] == 4'b0000) begin
               cnt_d = '0;
            end else if (cnt_q == 8'd0) begin
               fire  = 1'b1;
               cnt_d = RELOAD;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
      end

      always_ff @(posedge CLOCK_50 or posedge reset) begin
         if (reset)
            cnt_q <= '0;
         else
            cnt_q <= cnt_d;
      end

      assign sched[gi] = fire;
   end

   logic [1:0]      pend_q, pend_d;
   logic [1:0][1:0] pend_dir_q, pend_dir_d;
   logic [1:0]      avail;
   logic [1:0][1:0] cand_dir;
   logic            rr_q, rr_d;
   logic            valid_q, valid_d;
   logic            player_q, player_d;
   logic [1:0]      dir_q, dir_d;
   logic            overrun_q, overrun_d;
   logic            can_load, load, sel, taken;

   // A tick can feed the output stage directly when nothing is already pending.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         avail[p]    = pend_q[p] | sched[p];
         cand_dir[p] = pend_q[p] ? pend_dir_q[p] : last_dir[p];
      end
      can_load = !valid_q || move_ready;
      sel      = (avail == 2'b11) ? rr_q : avail[1];
      load     = can_load && (avail != 2'b00);
   end

   always_comb begin
      valid_d    = valid_q && !move_ready;
      player_d   = player_q;
      dir_d      = dir_q;
      rr_d       = rr_q;
      pend_d     = pend_q;
      pend_dir_d = pend_dir_q;
      overrun_d  = 1'b0;
      taken      = 1'b0;
      if (load) begin
         valid_d  = 1'b1;
         player_d = sel;
         dir_d    = cand_dir[sel];
         rr_d     = ~sel;
      end
      for (int p = 0; p < 2; p++) begin
         taken = load && (sel == p[0]);
         if (taken)
            pend_d[p] = 1'b0;
         // Skip re-pending only when this tick's move went straight to the output.
         if (sched[p] && !(taken && !pend_q[p])) begin
            pend_d[p]     = 1'b1;
            pend_dir_d[p] = last_dir[p];
            if (pend_q[p] && !taken)
               overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         pend_q     <= '0;
         pend_dir_q <= '0;
         rr_q       <= 1'b0;
         valid_q    <= 1'b0;
         player_q   <= 1'b0;
         dir_q      <= '0;
         overrun_q  <= 1'b0;
      end else begin
         pend_q     <= pend_d;
         pend_dir_q <= pend_dir_d;
         rr_q       <= rr_d;
         valid_q    <= valid_d;
         player_q   <= player_d;
         dir_q      <= dir_d;
         overrun_q  <= overrun_d;
      end
   end

   assign move_valid  = valid_q;
   assign move_player = player_q;
   assign move_dir    = dir_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_ps2_move_scheduler.sv
// Directed bench for ps2_move_scheduler: one instance with REPEAT_TICKS=1 and
// one with REPEAT_TICKS=3 share the same stimulus.
module tb_ps2_move_scheduler;

   logic       CLOCK_50 = 1'b0;
   logic       reset = 1'b0;
   logic       code_valid = 1'b0;
   logic [7:0] code = 8'h00;
   logic       game_tick = 1'b0;
   logic       move_ready = 1'b0;

   logic       mv, mp, ov;
   logic [1:0] md;
   logic [3:0] h0, h1;

   logic       r3_mv, r3_mp, r3_ov;
   logic [1:0] r3_md;
   logic [3:0] r3_h0, r3_h1;

   int checks = 0;
   int errors = 0;

   always #5 CLOCK_50 = ~CLOCK_50;

   ps2_move_scheduler #(.REPEAT_TICKS(1)) dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .code_valid  (code_valid),
      .code        (code),
      .game_tick   (game_tick),
      .move_ready  (move_ready),
      .move_valid  (mv),
      .move_player (mp),
      .move_dir    (md),
      .held_p0     (h0),
      .held_p1     (h1),
      .overrun     (ov)
   );

   ps2_move_scheduler #(.REPEAT_TICKS(3)) dut_r3 (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .code_valid  (code_valid),
      .code        (code),
      .game_tick   (game_tick),
      .move_ready  (move_ready),
      .move_valid  (r3_mv),
      .move_player (r3_mp),
      .move_dir    (r3_md),
      .held_p0     (r3_h0),
      .held_p1     (r3_h1),
      .overrun     (r3_ov)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge CLOCK_50);
      code_valid = 1'b1;
      code       = b;
      @(negedge CLOCK_50);
      code_valid = 1'b0;
      $display("code %02h  held_p0=%b held_p1=%b", b, h0, h1);
   endtask

   task automatic tick();
      @(negedge CLOCK_50);
      game_tick = 1'b1;
      @(negedge CLOCK_50);
      game_tick = 1'b0;
      $display("tick  valid=%b player=%b dir=%0d overrun=%b", mv, mp, md, ov);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   task automatic do_reset();
      @(negedge CLOCK_50);
      reset = 1'b1;
      @(negedge CLOCK_50);
      reset = 1'b0;
   endtask

   initial begin
      do_reset();
      check_eq("rst_valid", mv, 1'b0);
      check_eq("rst_player", mp, 1'b0);
      check_eq("rst_dir", md, 2'd0);
      check_eq("rst_held_p0", h0, 4'b0000);
      check_eq("rst_held_p1", h1, 4'b0000);
      check_eq("rst_overrun", ov, 1'b0);

      // W pressed, one tick, sink always ready: exactly one move.
      move_ready = 1'b1;
      send(8'h1D);
      check_eq("s1_held_p0", h0, 4'b0001);
      tick();
      check_eq("s1_valid", mv, 1'b1);
      check_eq("s1_player", mp, 1'b0);
      check_eq("s1_dir", md, 2'd0);
      idle(1);
      check_eq("s1_single", mv, 1'b0);
      idle(2);
      check_eq("s1_quiet", mv, 1'b0);

      // Both players on one tick; pointer now favours player 1; stall 3 cycles.
      move_ready = 1'b0;
      send(8'hE0);
      send(8'h75);
      send(8'h1C);
      check_eq("s2_held_p1", h1, 4'b0001);
      check_eq("s2_held_p0", h0, 4'b0101);
      tick();
      check_eq("s2_first_valid", mv, 1'b1);
      check_eq("s2_first_player", mp, 1'b1);
      check_eq("s2_first_dir", md, 2'd0);
      for (int i = 0; i < 3; i++) begin
         idle(1);
         check_eq("s2_stall_valid", mv, 1'b1);
         check_eq("s2_stall_player", mp, 1'b1);
         check_eq("s2_stall_dir", md, 2'd0);
      end
      move_ready = 1'b1;
      idle(1);
      check_eq("s2_second_valid", mv, 1'b1);
      check_eq("s2_second_player", mp, 1'b0);
      check_eq("s2_second_dir", md, 2'd2);
      idle(1);
      check_eq("s2_drained", mv, 1'b0);

      // Release of the active key falls back to the remaining held direction.
      do_reset();
      move_ready = 1'b1;
      send(8'h1D);
      send(8'h23);
      send(8'hF0);
      send(8'h23);
      check_eq("s3_held_p0", h0, 4'b0001);
      tick();
      check_eq("s3_valid", mv, 1'b1);
      check_eq("s3_player", mp, 1'b0);
      check_eq("s3_dir", md, 2'd0);
      idle(1);

      // REPEAT_TICKS=3 instance: S held over 7 ticks gives moves on 1, 4, 7.
      do_reset();
      move_ready = 1'b1;
      send(8'h1B);
      check_eq("s4_held_p0", r3_h0, 4'b0010);
      for (int t = 1; t <= 7; t++) begin
         logic exp_v;
         exp_v = (t == 1 || t == 4 || t == 7);
         tick();
         check_eq($sformatf("s4_tick%0d_valid", t), r3_mv, exp_v);
         if (exp_v)
            check_eq($sformatf("s4_tick%0d_dir", t), r3_md, 2'd1);
         idle(1);
      end

      // Keypad code without E0 is ignored; break of an unheld arrow changes nothing.
      do_reset();
      move_ready = 1'b1;
      send(8'h75);
      check_eq("s5_held_p1", h1, 4'b0000);
      check_eq("s5_held_p0", h0, 4'b0000);
      tick();
      check_eq("s5_no_move", mv, 1'b0);
      send(8'hF0);
      send(8'hE0);
      send(8'h72);
      check_eq("s5_break_unheld", h1, 4'b0000);
      send(8'hE0);
      send(8'h72);
      check_eq("s5_flags_cleared", h1, 4'b0010);

      // Stage held by player 1; A pending then overwritten on the next tick.
      do_reset();
      move_ready = 1'b0;
      send(8'hE0);
      send(8'h75);
      tick();
      check_eq("s6_offer_valid", mv, 1'b1);
      check_eq("s6_offer_player", mp, 1'b1);
      send(8'hF0);
      send(8'hE0);
      send(8'h75);
      check_eq("s6_released_p1", h1, 4'b0000);
      send(8'h1C);
      check_eq("s6_held_p0", h0, 4'b0100);
      tick();
      check_eq("s6_tick1_overrun", ov, 1'b0);
      check_eq("s6_tick1_player", mp, 1'b1);
      tick();
      check_eq("s6_tick2_overrun", ov, 1'b1);
      idle(1);
      check_eq("s6_overrun_pulse", ov, 1'b0);
      check_eq("s6_still_valid", mv, 1'b1);
      check_eq("s6_still_player", mp, 1'b1);
      check_eq("s6_still_dir", md, 2'd0);
      @(negedge CLOCK_50);
      reset = 1'b1;
      #1;
      check_eq("s6_rst_valid", mv, 1'b0);
      check_eq("s6_rst_player", mp, 1'b0);
      check_eq("s6_rst_held_p0", h0, 4'b0000);
      check_eq("s6_rst_overrun", ov, 1'b0);
      @(negedge CLOCK_50);
      reset = 1'b0;
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
